// File: rtl/seg_scan_controller.sv
// seg_scan_controller: scheduled scan of four 7-segment digits.
// Each digit slot has a fixed dwell and starts with an optional blank interval.
// Inputs are latched once per frame. PWM brightness and a per-digit enable gate the drive.
// Optional macro LEADING_ZERO_BLANK_EN enables leading-zero suppression.
//
// state   | meaning
// S_IDLE  | in reset or just released; the next edge starts slot 0
// S_BLANK | first BLANK_CYCLES cycles of a slot, all digits off
// S_ON    | rest of the slot, scheduled digit may be lit
module seg_scan_controller #(
    parameter int          CLK_DIV      = 50000,
    parameter int          BLANK_CYCLES = 500,
    parameter logic [7:0]  ZERO_GLYPH   = 8'hC0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data_0,
    input  logic [7:0] i_data_1,
    input  logic [7:0] i_data_2,
    input  logic [7:0] i_data_3,
    input  logic [3:0] i_digitEnable,
    input  logic [3:0] i_brightness,
    output logic [3:0] o_digitSelect,
    output logic [7:0] o_LED,
    output logic [1:0] o_ctrl,
    output logic       o_frameStart
);

    generate
        if (CLK_DIV < 2 || BLANK_CYCLES < 0 || BLANK_CYCLES >= CLK_DIV) begin : g_bad_params
            $error("seg_scan_controller: need CLK_DIV >= 2 and 0 <= BLANK_CYCLES < CLK_DIV");
        end
    endgenerate

    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLNK = CW'(BLANK_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ON} state_t;

    state_t          r_state, w_state;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic [1:0]      r_dig, w_dig;
    logic [3:0]      r_pwm, w_pwm;
    logic [3:0][7:0] r_lat_data, w_lat_data;
    logic [3:0]      r_lat_en, w_lat_en;
    logic [3:0]      r_lat_br, w_lat_br;
    logic [3:0]      r_sup, w_sup, w_sup_new;
    logic            w_frame;
    logic            w_first_on;
    logic            w_lit;
    logic [3:0]      w_sel_nxt;
    logic [7:0]      w_led_nxt;
    logic [3:0]      r_sel;
    logic [7:0]      r_led;
    logic [1:0]      r_ctrl;
    logic            r_frame;

    // State register: slot position, digit index, PWM counter and frame latches
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_dig      <= 2'd0;
            r_pwm      <= 4'd0;
            r_lat_data <= '0;
            r_lat_en   <= 4'd0;
            r_lat_br   <= 4'd0;
            r_sup      <= 4'd0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_dig      <= w_dig;
            r_pwm      <= w_pwm;
            r_lat_data <= w_lat_data;
            r_lat_en   <= w_lat_en;
            r_lat_br   <= w_lat_br;
            r_sup      <= w_sup;
        end
    end

    // Next state: advance the slot position; leaving IDLE always lands on slot 0, digit 0
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_dig   = r_dig;
        if (r_state == S_IDLE || r_cnt == LAST) begin
            w_cnt   = '0;
            w_dig   = (r_state == S_IDLE) ? 2'd0 : r_dig + 2'd1;
            w_state = (BLANK_CYCLES == 0) ? S_ON : S_BLANK;
        end else begin
            w_cnt = r_cnt + CW'(1);
            if (w_cnt == BLNK) begin
                w_state = S_ON;
            end
        end

        w_frame    = (w_cnt == '0) && (w_dig == 2'd0);
        w_first_on = (w_state == S_ON) && (w_cnt == BLNK);

        w_pwm = r_pwm;
        if (w_first_on) begin
            w_pwm = 4'd0;
        end else if (w_state == S_ON) begin
            w_pwm = r_pwm + 4'd1;
        end

        // The latched view is bypassed on the latching cycle so cycle 0 already sees new data
        w_lat_data = r_lat_data;
        w_lat_en   = r_lat_en;
        w_lat_br   = r_lat_br;
        w_sup      = r_sup;
        if (w_frame) begin
            w_lat_data = {i_data_3, i_data_2, i_data_1, i_data_0};
            w_lat_en   = i_digitEnable;
            w_lat_br   = i_brightness;
            w_sup      = w_sup_new;
        end
    end

    // Leading-zero suppression mask computed from the incoming frame data
`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        w_sup_new    = 4'd0;
        w_sup_new[3] = (i_data_3 == ZERO_GLYPH);
        w_sup_new[2] = w_sup_new[3] && (i_data_2 == ZERO_GLYPH);
        w_sup_new[1] = w_sup_new[2] && (i_data_1 == ZERO_GLYPH);
    end
`else
    assign w_sup_new = 4'd0;
`endif

    // Output decode for the upcoming cycle: lit only in ON, enabled, within PWM duty, not suppressed
    always_comb begin
        w_lit = (w_state == S_ON)
              && w_lat_en[w_dig]
              && ((w_pwm < w_lat_br) || (w_lat_br == 4'd15))
              && !w_sup[w_dig];
        w_sel_nxt = 4'b1111;
        w_led_nxt = 8'hFF;
        if (w_lit) begin
            w_sel_nxt = ~(4'b0001 << w_dig);
            w_led_nxt = w_lat_data[w_dig];
        end
    end

    // Output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sel   <= 4'b1111;
            r_led   <= 8'hFF;
            r_ctrl  <= 2'd0;
            r_frame <= 1'b0;
        end else begin
            r_sel   <= w_sel_nxt;
            r_led   <= w_led_nxt;
            r_ctrl  <= w_dig;
            r_frame <= w_frame;
        end
    end

    assign o_digitSelect = r_sel;
    assign o_LED         = r_led;
    assign o_ctrl        = r_ctrl;
    assign o_frameStart  = r_frame;

endmodule
